// File: rtl/ram_4x8_initiator.sv
// Initiator-side sequencer for the 4x8 RAM port.
// It accepts one read or write per valid/ready request, holds the address and
// data through a programmable setup window, and then strobes the access for
// one cycle. It returns the result on a valid/ready response channel and
// counts completed reads and writes separately.
module ram_4x8_initiator #(
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned DATA_W       = 8
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_addr1,
  output logic              mem_addr2,
  output logic              mem_rw,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        wr_count,
  output logic [7:0]        rd_count
);

  localparam int unsigned SETUP_W = 4;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t             state;
  logic [SETUP_W-1:0] setup_cnt;
  logic               wr_lat;

  // Sequencer: all outputs are registered and only change on state transitions.
  // mem_rw is set when SETUP exits into ACCESS, so the strobe is high only
  // during ACCESS.
  always_ff @(posedge clk) begin
    if (!clear) begin
      state     <= IDLE;
      setup_cnt <= '0;
      wr_lat    <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      mem_addr1 <= 1'b0;
      mem_addr2 <= 1'b0;
      mem_rw    <= 1'b0;
      mem_wdata <= '0;
      wr_count  <= '0;
      rd_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            mem_addr1 <= req_addr[0];
            mem_addr2 <= req_addr[1];
            mem_wdata <= req_wdata;
            wr_lat    <= req_write;
            setup_cnt <= SETUP_W'(SETUP_CYCLES - 1);
            req_ready <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (setup_cnt == '0) begin
            mem_rw <= wr_lat;
            state  <= ACCESS;
          end else begin
            setup_cnt <= setup_cnt - SETUP_W'(1);
          end
        end
        ACCESS: begin
          mem_rw    <= 1'b0;
          rsp_write <= wr_lat;
          rsp_valid <= 1'b1;
          if (wr_lat) begin
            rsp_rdata <= mem_wdata;
            wr_count  <= wr_count + CNT_W'(1);
          end else begin
            rsp_rdata <= mem_rdata;
            rd_count  <= rd_count + CNT_W'(1);
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_4x8_initiator.sv
// Directed bench for ram_4x8_initiator with SETUP_CYCLES=1 and SETUP_CYCLES=3 instances.
module tb_ram_4x8_initiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clear;

  // SETUP_CYCLES = 1 instance
  logic       req_valid, req_ready, req_write;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_ready, rsp_write;
  logic [7:0] rsp_rdata;
  logic       mem_addr1, mem_addr2, mem_rw;
  logic [7:0] mem_wdata, mem_rdata, wr_count, rd_count;

  // SETUP_CYCLES = 3 instance
  logic       s3_req_valid, s3_req_ready, s3_req_write;
  logic [1:0] s3_req_addr;
  logic [7:0] s3_req_wdata;
  logic       s3_rsp_valid, s3_rsp_ready, s3_rsp_write;
  logic [7:0] s3_rsp_rdata;
  logic       s3_mem_addr1, s3_mem_addr2, s3_mem_rw;
  logic [7:0] s3_mem_wdata, s3_mem_rdata, s3_wr_count, s3_rd_count;

  ram_4x8_initiator #(.SETUP_CYCLES(1), .DATA_W(8)) u1 (
    .clk(clk), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata),
    .mem_addr1(mem_addr1), .mem_addr2(mem_addr2), .mem_rw(mem_rw),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  ram_4x8_initiator #(.SETUP_CYCLES(3), .DATA_W(8)) u3 (
    .clk(clk), .clear(clear),
    .req_valid(s3_req_valid), .req_ready(s3_req_ready), .req_write(s3_req_write),
    .req_addr(s3_req_addr), .req_wdata(s3_req_wdata),
    .rsp_valid(s3_rsp_valid), .rsp_ready(s3_rsp_ready), .rsp_write(s3_rsp_write),
    .rsp_rdata(s3_rsp_rdata),
    .mem_addr1(s3_mem_addr1), .mem_addr2(s3_mem_addr2), .mem_rw(s3_mem_rw),
    .mem_wdata(s3_mem_wdata), .mem_rdata(s3_mem_rdata),
    .wr_count(s3_wr_count), .rd_count(s3_rd_count)
  );

  // 4x8 RAM models: preloaded while clear is low, write on the edge closing a strobe
  logic [7:0] ram1 [4];
  logic [7:0] ram3 [4];

  always @(posedge clk) begin
    if (!clear) begin
      ram1[0] <= 8'h77; ram1[1] <= 8'h3C; ram1[2] <= 8'h00; ram1[3] <= 8'h00;
    end else if (mem_rw) begin
      ram1[{mem_addr2, mem_addr1}] <= mem_wdata;
    end
  end

  always @(posedge clk) begin
    if (!clear) begin
      ram3[0] <= 8'h00; ram3[1] <= 8'h00; ram3[2] <= 8'h00; ram3[3] <= 8'h00;
    end else if (s3_mem_rw) begin
      ram3[{s3_mem_addr2, s3_mem_addr1}] <= s3_mem_wdata;
    end
  end

  assign mem_rdata    = ram1[{mem_addr2, mem_addr1}];
  assign s3_mem_rdata = ram3[{s3_mem_addr2, s3_mem_addr1}];

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_wr = 8'd0, exp_rd = 8'd0;
  logic [7:0] exp3_wr = 8'd0, exp3_rd = 8'd0;

  typedef struct {
    logic       w;
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full transaction on u1 with rsp_ready held high, checked cycle by cycle
  task automatic do_txn(input logic w, input logic [1:0] a, input logic [7:0] d, input logic [7:0] exp);
    check("idle_req_ready", req_ready, 1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; rsp_ready = 1'b1;
    tick;
    req_valid = 1'b0;
    check("setup_req_ready", req_ready, 0);
    check("setup_mem_rw", mem_rw, 0);
    check("mem_addr1", mem_addr1, a[0]);
    check("mem_addr2", mem_addr2, a[1]);
    check("mem_wdata", mem_wdata, d);
    check("setup_rsp_valid", rsp_valid, 0);
    tick;
    check("access_mem_rw", mem_rw, w);
    check("access_rsp_valid", rsp_valid, 0);
    tick;
    if (w) exp_wr = exp_wr + 8'd1;
    else   exp_rd = exp_rd + 8'd1;
    check("resp_valid", rsp_valid, 1);
    check("resp_write", rsp_write, w);
    check("resp_rdata", rsp_rdata, exp);
    check("resp_mem_rw", mem_rw, 0);
    check("wr_count", wr_count, exp_wr);
    check("rd_count", rd_count, exp_rd);
    tick;
    check("done_rsp_valid", rsp_valid, 0);
    check("done_req_ready", req_ready, 1);
  endtask

  // Transaction on u3; measures accept-to-next-accept spacing
  task automatic s3_txn(input logic w, input logic [1:0] a, input logic [7:0] d, input logic [7:0] exp);
    logic seen;
    int   spacing;
    seen = 1'b0;
    spacing = 0;
    check("s3_idle_ready", s3_req_ready, 1);
    s3_req_valid = 1'b1; s3_req_write = w; s3_req_addr = a; s3_req_wdata = d; s3_rsp_ready = 1'b1;
    tick;
    s3_req_valid = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (k < 3) begin
        check("s3_setup_rw", s3_mem_rw, 0);
        check("s3_setup_addr", {s3_mem_addr2, s3_mem_addr1}, a);
        check("s3_setup_wdata", s3_mem_wdata, d);
      end
      if (k == 3) check("s3_access_rw", s3_mem_rw, w);
      if (k == 4) begin
        if (w) exp3_wr = exp3_wr + 8'd1;
        else   exp3_rd = exp3_rd + 8'd1;
        check("s3_resp_valid", s3_rsp_valid, 1);
        check("s3_resp_rdata", s3_rsp_rdata, exp);
        check("s3_resp_write", s3_rsp_write, w);
        check("s3_wr_count", s3_wr_count, exp3_wr);
        check("s3_rd_count", s3_rd_count, exp3_rd);
      end
      if (s3_req_ready) begin
        seen = 1'b1;
        spacing = k + 1;
      end else begin
        tick;
      end
    end
    check("s3_ready_return", seen, 1);
    check("s3_spacing", spacing, 6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{w: 1'b1, a: 2'd2, d: 8'hA5, exp: 8'hA5};
    vecs[1] = '{w: 1'b0, a: 2'd1, d: 8'hEE, exp: 8'h3C};
    vecs[2] = '{w: 1'b0, a: 2'd2, d: 8'hEE, exp: 8'hA5};
    vecs[3] = '{w: 1'b1, a: 2'd3, d: 8'h5A, exp: 8'h5A};
    vecs[4] = '{w: 1'b0, a: 2'd3, d: 8'h12, exp: 8'h5A};
    vecs[5] = '{w: 1'b0, a: 2'd0, d: 8'hEE, exp: 8'h77};
    vecs[6] = '{w: 1'b1, a: 2'd0, d: 8'h00, exp: 8'h00};
    vecs[7] = '{w: 1'b0, a: 2'd0, d: 8'hFF, exp: 8'h00};

    clear = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 2'd0; req_wdata = 8'd0; rsp_ready = 1'b1;
    s3_req_valid = 1'b0; s3_req_write = 1'b0; s3_req_addr = 2'd0; s3_req_wdata = 8'd0; s3_rsp_ready = 1'b1;
    tick;
    tick;

    // Reset state
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_write", rsp_write, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_mem_addr1", mem_addr1, 0);
    check("rst_mem_addr2", mem_addr2, 0);
    check("rst_mem_rw", mem_rw, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_rd_count", rd_count, 0);
    check("rst_s3_req_ready", s3_req_ready, 1);
    check("rst_s3_rsp_valid", s3_rsp_valid, 0);
    clear = 1'b1;
    tick;

    // Table-driven transactions
    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp);
    end

    // Response backpressure while a new request waits
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd2; req_wdata = 8'h00;
    tick;
    req_write = 1'b1; req_addr = 2'd1; req_wdata = 8'h11;
    tick;
    tick;
    exp_rd = exp_rd + 8'd1;
    check("bp_rsp_valid", rsp_valid, 1);
    check("bp_rsp_rdata", rsp_rdata, 8'hA5);
    check("bp_rd_count", rd_count, exp_rd);
    for (int i = 0; i < 5; i++) begin
      tick;
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_rdata", rsp_rdata, 8'hA5);
      check("bp_hold_write", rsp_write, 0);
      check("bp_hold_req_ready", req_ready, 0);
      check("bp_hold_addr1", mem_addr1, 0);
    end
    rsp_ready = 1'b1;
    tick;
    check("bp_release_ready", req_ready, 1);
    check("bp_release_valid", rsp_valid, 0);
    check("bp_not_yet_accepted", mem_addr1, 0);
    tick;
    req_valid = 1'b0;
    check("bp_accept_ready", req_ready, 0);
    check("bp_accept_addr1", mem_addr1, 1);
    check("bp_accept_wdata", mem_wdata, 8'h11);
    tick;
    check("bp_access_rw", mem_rw, 1);
    tick;
    exp_wr = exp_wr + 8'd1;
    check("bp_resp_rdata", rsp_rdata, 8'h11);
    check("bp_resp_write", rsp_write, 1);
    check("bp_wr_count", wr_count, exp_wr);
    tick;
    check("bp_done_ready", req_ready, 1);

    // Reset during a write ACCESS cycle
    req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd0; req_wdata = 8'h99;
    tick;
    req_valid = 1'b0;
    tick;
    check("abort_access_rw", mem_rw, 1);
    clear = 1'b0;
    tick;
    clear = 1'b1;
    exp_wr = 8'd0;
    exp_rd = 8'd0;
    check("abort_mem_rw", mem_rw, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_req_ready", req_ready, 1);
    check("abort_wr_count", wr_count, 0);
    check("abort_rd_count", rd_count, 0);
    for (int i = 0; i < 6; i++) begin
      tick;
      check("abort_no_rsp", rsp_valid, 0);
    end

    // Write counter wrap
    for (int i = 0; i < 256; i++) begin
      do_txn(1'b1, 2'(i), 8'(i), 8'(i));
    end
    check("wrap_wr_256", wr_count, 0);
    check("wrap_rd_unchanged", rd_count, 0);
    do_txn(1'b1, 2'd1, 8'h42, 8'h42);
    check("wrap_wr_257", wr_count, 1);
    check("wrap_rd_still", rd_count, 0);

    // SETUP_CYCLES = 3: write then read back
    s3_txn(1'b1, 2'd1, 8'hFF, 8'hFF);
    s3_txn(1'b0, 2'd1, 8'h00, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
